// File: rtl/mf2_controller.sv
// Multiface-style NMI snapshot controller: debounced NMI key, MF ROM/RAM
// paging with hide latch, 8 KB on-chip MF RAM and shadow capture of the
// write-only CPC hardware registers into fixed MF RAM slots.
module mf2_controller #(
  parameter int PENS     = 16,
  parameter int CRTC_RB  = 4,
  parameter int DEBOUNCE = 65535,
  parameter int HIDE_EN  = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        key_nmi,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        m1,
  input  logic        io_wr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  output logic        nmi,
  output logic        mf_en,
  output logic        mf_hidden,
  output logic        mf_rom_en,
  output logic        mf_ram_en,
  output logic [7:0]  dout,
  output logic        nmi_ack
);

  localparam int PW  = $clog2(PENS) + 1;
  localparam int DBW = $clog2(DEBOUNCE + 1);

  // ---------------------------------------------------------------------
  // state
  logic [DBW-1:0]     db_cnt_q, db_cnt_d;
  logic               key_db_q;
  logic               m1_q, io_wr_q;
  logic               nmi_q, nmi_d;
  logic               mf_en_q, mf_en_d;
  logic               hid_q, hid_d;
  logic               ack_q, ack_d;
  logic [PW-1:0]      pen_q, pen_d;
  logic [CRTC_RB-1:0] crtc_q, crtc_d;
  logic [7:0]         ram_q [0:8191];
  logic [7:0]         rd_q;

  // ---------------------------------------------------------------------
  // decode
  logic        key_db, key_rise, m1_rise, io_rise, page_sel, ack_ev;
  logic        cap_we, cpu_we, ram_we;
  logic [12:0] cap_slot, pen_slot, ram_wa;

  assign key_db   = (db_cnt_q == DBW'(DEBOUNCE));
  assign key_rise = key_db & ~key_db_q;
  assign m1_rise  = m1 & ~m1_q;
  assign io_rise  = io_wr & ~io_wr_q;
  assign page_sel = (cpu_addr[15:2] == 14'h3FBA);
  assign ack_ev   = m1_rise & nmi_q & (cpu_addr == 16'h0066);

  // Border is the top index bit; with 32 pens the upper bank sits below
  // the lower one in RAM (0x1F80..0x1F8F vs 0x1F90..0x1F9F).
  assign pen_slot = pen_q[PW-1]                ? 13'h1FDF :
                    ((PENS > 16) && pen_q[4])  ? {9'h1F8, pen_q[3:0]} :
                                                 {9'h1F9, pen_q[3:0]};

  // Key debounce counter: count up while held, saturate at DEBOUNCE, clear on release
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (!key_nmi)     db_cnt_d = '0;
    else if (!key_db) db_cnt_d = db_cnt_q + DBW'(1);
  end

  // NMI / paging / hide control; later assignments carry higher priority
  always_comb begin
    nmi_d   = nmi_q;
    mf_en_d = mf_en_q;
    hid_d   = hid_q;
    ack_d   = 1'b0;
    if (key_rise && !mf_en_q) nmi_d = 1'b1;
    if (ack_ev) begin
      nmi_d   = 1'b0;
      mf_en_d = 1'b1;
      hid_d   = 1'b0;
      ack_d   = 1'b1;
    end
    if ((HIDE_EN != 0) && mf_en_q && m1_rise && (cpu_addr == 16'h0065)) hid_d = 1'b1;
    if (io_rise && page_sel) begin
      case (cpu_addr[1:0])
        2'b00:   mf_en_d = ~hid_q;
        2'b10:   mf_en_d = 1'b0;
        default: ;
      endcase
    end
  end

  // Shadow capture of hardware register writes into fixed RAM slots
  always_comb begin
    cap_we   = 1'b0;
    cap_slot = '0;
    pen_d    = pen_q;
    crtc_d   = crtc_q;
    if (io_rise && !page_sel) begin
      case (cpu_addr[15:8])
        8'h7F: begin
          cap_we = 1'b1;
          case (cpu_dout[7:6])
            2'b00: begin
              cap_slot = 13'h1FCF;
              pen_d    = cpu_dout[PW-1:0];
            end
            2'b01:   cap_slot = pen_slot;
            2'b10:   cap_slot = 13'h1FEF;
            default: cap_slot = 13'h1FFF;
          endcase
        end
        8'hBC: begin
          cap_we   = 1'b1;
          cap_slot = 13'h1CFF;
          crtc_d   = cpu_dout[CRTC_RB-1:0];
        end
        8'hBD: begin
          cap_we   = 1'b1;
          cap_slot = 13'h1DB0 + 13'(crtc_q);
        end
        8'hF7: begin
          cap_we   = 1'b1;
          cap_slot = 13'h17FF;
        end
        8'hDF: begin
          cap_we   = 1'b1;
          cap_slot = 13'h1AAC;
        end
        default: ;
      endcase
    end
  end

  // A CPU write losing to a capture simply retries next cycle (mem_wr is a level)
  assign cpu_we = mem_wr & mf_ram_en & ~cap_we;
  assign ram_we = ~reset & (cap_we | cpu_we);
  assign ram_wa = cap_we ? cap_slot : cpu_addr[12:0];

  // Edge-detect history for m1 and io_wr; kept running through reset so
  // leaving reset never fakes an edge
  always_ff @(posedge clk_sys) begin
    m1_q    <= m1;
    io_wr_q <= io_wr;
  end

  // Control and latch registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      db_cnt_q <= '0;
      key_db_q <= 1'b0;
      nmi_q    <= 1'b0;
      mf_en_q  <= 1'b0;
      hid_q    <= 1'b0;
      ack_q    <= 1'b0;
      pen_q    <= '0;
      crtc_q   <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
      key_db_q <= key_db;
      nmi_q    <= nmi_d;
      mf_en_q  <= mf_en_d;
      hid_q    <= hid_d;
      ack_q    <= ack_d;
      pen_q    <= pen_d;
      crtc_q   <= crtc_d;
    end
  end

  // Single-port MF RAM, write-first read register; contents survive reset
  always_ff @(posedge clk_sys) begin
    if (ram_we) ram_q[ram_wa] <= cpu_dout;
    rd_q <= ram_we ? cpu_dout : ram_q[cpu_addr[12:0]];
  end

  assign nmi       = nmi_q;
  assign mf_en     = mf_en_q;
  assign mf_hidden = hid_q;
  assign nmi_ack   = ack_q;
  assign mf_rom_en = mf_en_q & (cpu_addr[15:13] == 3'd0);
  assign mf_ram_en = mf_en_q & (cpu_addr[15:13] == 3'd1);
  assign dout      = (mf_ram_en & mem_rd) ? rd_q : 8'hFF;

endmodule

// File: tb/tb_mf2_controller.sv
// Bench for mf2_controller: two instances share one stimulus stream
// (A: 16 pens, hide on; B: 32 pens, 5 CRTC bits, hide off).
module tb_mf2_controller;
  localparam int DB = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        key_nmi = 1'b0, m1 = 1'b0, io_wr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;

  logic       nmi_a, en_a, hid_a, rom_a, ram_a, ack_a;
  logic       nmi_b, en_b, hid_b, rom_b, ram_b, ack_b;
  logic [7:0] dout_a, dout_b;

  mf2_controller #(.PENS(16), .CRTC_RB(4), .DEBOUNCE(DB), .HIDE_EN(1)) u_a (
    .clk_sys(clk_sys), .reset(reset), .key_nmi(key_nmi), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .m1(m1), .io_wr(io_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .nmi(nmi_a), .mf_en(en_a), .mf_hidden(hid_a), .mf_rom_en(rom_a),
    .mf_ram_en(ram_a), .dout(dout_a), .nmi_ack(ack_a));

  mf2_controller #(.PENS(32), .CRTC_RB(5), .DEBOUNCE(DB), .HIDE_EN(0)) u_b (
    .clk_sys(clk_sys), .reset(reset), .key_nmi(key_nmi), .cpu_addr(cpu_addr),
    .cpu_dout(cpu_dout), .m1(m1), .io_wr(io_wr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .nmi(nmi_b), .mf_en(en_b), .mf_hidden(hid_b), .mf_rom_en(rom_b),
    .mf_ram_en(ram_b), .dout(dout_b), .nmi_ack(ack_b));

  always #5 clk_sys = ~clk_sys;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ctl(input string t, input logic n, input logic e, input logic h, input logic k,
                     input logic nb, input logic eb, input logic hb, input logic kb);
    chk({t, ".nmi_a"}, nmi_a, n);  chk({t, ".en_a"}, en_a, e);
    chk({t, ".hid_a"}, hid_a, h);  chk({t, ".ack_a"}, ack_a, k);
    chk({t, ".nmi_b"}, nmi_b, nb); chk({t, ".en_b"}, en_b, eb);
    chk({t, ".hid_b"}, hid_b, hb); chk({t, ".ack_b"}, ack_b, kb);
  endtask

  // read scoreboard: pushed when the read is driven, compared 1 cycle later
  typedef struct { logic [15:0] a; logic [7:0] ea; logic [7:0] eb; bit va; bit vb; } rd_t;
  rd_t sbq[$];
  rd_t se;

  always @(posedge clk_sys) begin
    #1;
    if (sbq.size() != 0) begin
      se = sbq.pop_front();
      if (se.va) chk($sformatf("dout_a@%h", se.a), dout_a, se.ea);
      if (se.vb) chk($sformatf("dout_b@%h", se.a), dout_b, se.eb);
    end
  end

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic out_io(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; io_wr = 1'b1;
    tick();
    io_wr = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] ea, input logic [7:0] eb,
                    input bit va, input bit vb, input logic rden);
    cpu_addr = a; mem_rd = rden;
    sbq.push_back('{a, ea, eb, va, vb});
    tick();
  endtask

  logic [7:0] mdl_a [int];
  logic [7:0] mdl_b [int];

  task automatic readback();
    foreach (mdl_a[k])
      rd(16'h2000 | 16'(k), mdl_a[k], mdl_b.exists(k) ? mdl_b[k] : 8'h00, 1'b1,
         mdl_b.exists(k) != 0, 1'b1);
    foreach (mdl_b[k])
      if (!mdl_a.exists(k)) rd(16'h2000 | 16'(k), 8'h00, mdl_b[k], 1'b0, 1'b1, 1'b1);
    mem_rd = 1'b0;
    tick();
  endtask

  typedef struct { logic [15:0] port; logic [7:0] data; logic [12:0] sa; logic [12:0] sb; bit wr; } cap_t;
  cap_t caps [17];

  initial begin
    caps[0]  = '{16'h7F00, 8'h05, 13'h1FCF, 13'h1FCF, 1'b1};
    caps[1]  = '{16'h7F00, 8'h4A, 13'h1F95, 13'h1F95, 1'b1};
    caps[2]  = '{16'hBC00, 8'h0C, 13'h1CFF, 13'h1CFF, 1'b1};
    caps[3]  = '{16'hBD00, 8'h30, 13'h1DBC, 13'h1DBC, 1'b1};
    caps[4]  = '{16'h7F00, 8'h14, 13'h1FCF, 13'h1FCF, 1'b1};
    caps[5]  = '{16'h7F00, 8'h55, 13'h1FDF, 13'h1F84, 1'b1};
    caps[6]  = '{16'h7F00, 8'h8C, 13'h1FEF, 13'h1FEF, 1'b1};
    caps[7]  = '{16'h7F00, 8'hC1, 13'h1FFF, 13'h1FFF, 1'b1};
    caps[8]  = '{16'hF700, 8'h82, 13'h17FF, 13'h17FF, 1'b1};
    caps[9]  = '{16'hDF00, 8'h07, 13'h1AAC, 13'h1AAC, 1'b1};
    caps[10] = '{16'hBC00, 8'h13, 13'h1CFF, 13'h1CFF, 1'b1};
    caps[11] = '{16'hBD00, 8'h44, 13'h1DB3, 13'h1DC3, 1'b1};
    caps[12] = '{16'h7F00, 8'h20, 13'h1FCF, 13'h1FCF, 1'b1};
    caps[13] = '{16'h7F00, 8'h66, 13'h1F90, 13'h1FDF, 1'b1};
    caps[14] = '{16'h1234, 8'hEE, 13'h0000, 13'h0000, 1'b0};
    caps[15] = '{16'h7F00, 8'h03, 13'h1FCF, 13'h1FCF, 1'b1};
    caps[16] = '{16'h7F00, 8'h7B, 13'h1F93, 13'h1F93, 1'b1};

    // reset state
    repeat (3) tick();
    ctl("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.dout_a", dout_a, 8'hFF);
    reset = 1'b0;
    tick();

    // press one cycle short of the debounce window: no NMI
    key_nmi = 1'b1;
    repeat (DB - 1) tick();
    key_nmi = 1'b0;
    repeat (4) begin
      tick();
      chk("short.nmi_a", nmi_a, 1'b0);
      chk("short.nmi_b", nmi_b, 1'b0);
    end

    // full press: nmi rises exactly after DB+1 cycles
    key_nmi = 1'b1;
    for (int i = 1; i <= DB + 1; i++) begin
      tick();
      chk($sformatf("long%0d.nmi_a", i), nmi_a, 8'(i == DB + 1));
      chk($sformatf("long%0d.nmi_b", i), nmi_b, 8'(i == DB + 1));
    end
    key_nmi = 1'b0;

    // acknowledge at 0x0066
    cpu_addr = 16'h0066; m1 = 1'b1;
    tick();
    ctl("ack", 0, 1, 0, 1, 0, 1, 0, 1);
    tick();
    chk("ack2.ack_a", ack_a, 1'b0);
    chk("ack2.ack_b", ack_b, 1'b0);
    m1 = 1'b0; cpu_addr = 16'h1234;
    tick();
    chk("rom.rom_a", rom_a, 1'b1); chk("rom.ram_a", ram_a, 1'b0);
    cpu_addr = 16'h2000;
    tick();
    chk("ram.ram_a", ram_a, 1'b1); chk("ram.rom_a", rom_a, 1'b0);

    // shadow capture table
    for (int i = 0; i < 17; i++) begin
      out_io(caps[i].port, caps[i].data);
      if (caps[i].wr) begin
        mdl_a[int'(caps[i].sa)] = caps[i].data;
        mdl_b[int'(caps[i].sb)] = caps[i].data;
      end
      if (i == 3) readback();
    end
    readback();

    // CPU write, read back, idle read, write-first, out-of-window read
    cpu_addr = 16'h2010; cpu_dout = 8'hA5; mem_wr = 1'b1;
    tick();
    mem_wr = 1'b0;
    rd(16'h2010, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1);
    rd(16'h2010, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    cpu_dout = 8'h3C; mem_wr = 1'b1;
    rd(16'h2011, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1);
    mem_wr = 1'b0;
    rd(16'h4010, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
    mem_rd = 1'b0;
    tick();

    // hide latch, then page out / page in
    cpu_addr = 16'h0065; m1 = 1'b1;
    tick();
    m1 = 1'b0;
    ctl("hide", 0, 1, 1, 0, 0, 1, 0, 0);
    out_io(16'hFEEA, 8'h00);
    ctl("feea", 0, 0, 1, 0, 0, 0, 0, 0);
    out_io(16'hFEE8, 8'h00);
    ctl("fee8", 0, 0, 1, 0, 0, 1, 0, 0);

    // key while paged in (B) is ignored; A is paged out and goes pending
    key_nmi = 1'b1;
    repeat (DB + 2) tick();
    ctl("keyen", 1, 0, 1, 0, 0, 1, 0, 0);
    key_nmi = 1'b0;
    tick();

    // acknowledge and a fresh key edge in the same cycle: ack wins
    key_nmi = 1'b1;
    repeat (DB) tick();
    cpu_addr = 16'h0066; m1 = 1'b1;
    tick();
    ctl("ackkey", 0, 1, 0, 1, 0, 1, 0, 0);
    m1 = 1'b0; key_nmi = 1'b0;
    tick();

    // reset while pending clears nmi
    out_io(16'hFEEA, 8'h00);
    key_nmi = 1'b1;
    repeat (DB + 1) tick();
    ctl("pend", 1, 0, 0, 0, 1, 0, 0, 0);
    key_nmi = 1'b0; reset = 1'b1;
    tick();
    ctl("rstpend", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // RAM contents survive reset
    out_io(16'hFEE8, 8'h00);
    chk("repage.en_a", en_a, 1'b1);
    chk("repage.en_b", en_b, 1'b1);
    rd(16'h3FCF, mdl_a[int'(13'h1FCF)], mdl_b[int'(13'h1FCF)], 1'b1, 1'b1, 1'b1);
    rd(16'h3F84, 8'h00, mdl_b[int'(13'h1F84)], 1'b0, 1'b1, 1'b1);
    mem_rd = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
